// File: rtl/serial_sum_deserializer.sv
// serial_sum_deserializer: assembles an LSB-first serial sum plus final carry into a parallel word with valid/ready output
module serial_sum_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             frame_abort,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2;
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] shreg, shifted;
  logic [CW-1:0] count;
  logic last, clear, shift_en, accept;
  always_comb begin
    shifted = {sum_bit, shreg[WIDTH-1:1]};
    last = count == CW'(WIDTH - 1);
    accept = state == HOLD && result_ready;
    clear = start && (state != HOLD || result_ready);
    shift_en = state == COLLECT && !start && bit_valid;
    state_nxt = state == IDLE ? (start ? COLLECT : IDLE) :
                state == COLLECT ? ((shift_en && last) ? HOLD : COLLECT) :
                accept ? (start ? COLLECT : IDLE) : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      result <= '0;
      cout <= 1'b0;
      result_valid <= 1'b0;
      busy <= 1'b0;
      frame_abort <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt == COLLECT;
      frame_abort <= state == COLLECT && start;
      overrun <= state == HOLD && bit_valid;
      if (clear) begin
        shreg <= '0;
        count <= '0;
      end else if (shift_en) begin
        shreg <= shifted;
        count <= last ? '0 : count + CW'(1);
      end
      if (shift_en && last) begin
        result <= shifted;
        cout <= carry_bit;
        result_valid <= 1'b1;
      end else if (accept) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule
